// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and helpers for the DDR port arbiter.
package ddr_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int PERF_W = 32;
    function automatic int gnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ddr_arb_rr_pick.sv
// ddr_arb_rr_pick: combinational round-robin picker, first request after last_ptr wins.
module ddr_arb_rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = gnt_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_ptr,
    output logic [GW-1:0] pick,
    output logic          any_req
);
    logic [GW-1:0] idx;
    always_comb begin
        pick = '0;
        idx  = '0;
        // Scan farthest-first so the nearest requester after last_ptr overwrites last.
        for (int k = N; k >= 1; k--) begin
            idx = GW'((int'(last_ptr) + k) % N);
            if (req[idx]) pick = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin sharing of the DDR controller port with MAX_HOLD burst hold.
// Optional per-port performance counters under DDR_ARB_PERF_CNT_EN.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_HOLD   = 8
) (
    input  logic                             mem_clk,
    input  logic                             mem_rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             req_rvalid,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic [ADDR_WIDTH-1:0]            ctl_addr,
    output logic [DATA_WIDTH-1:0]            ctl_wdata,
    output logic                             ctl_valid,
    output logic                             ctl_write,
    input  logic                             ctl_ready,
    input  logic [DATA_WIDTH-1:0]            ctl_rdata,
    input  logic                             perf_clr,
    output logic [NUM_PORTS*PERF_W-1:0]      perf_cnt
);
    localparam int GW = gnt_w(NUM_PORTS);
    localparam int HW = $clog2(MAX_HOLD) + 1;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_ptr_q, last_ptr_d, pick;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          any_req, hs;

    ddr_arb_rr_pick #(.N(NUM_PORTS), .GW(GW)) u_pick (
        .req      (req_valid),
        .last_ptr (last_ptr_q),
        .pick     (pick),
        .any_req  (any_req)
    );

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_ptr_q <= GW'(NUM_PORTS - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        if (state_q == IDLE) begin
            if (any_req) begin
                state_d    = BUSY;
                grant_d    = pick;
                hold_cnt_d = '0;
            end
        end else if (!req_valid[grant_q] || (hs && hold_cnt_q == HW'(MAX_HOLD - 1))) begin
            state_d    = IDLE;
            last_ptr_d = grant_q;
        end else if (hs) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_comb begin
        ctl_valid  = (state_q == BUSY) & req_valid[grant_q];
        ctl_write  = req_write[grant_q];
        ctl_addr   = req_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        ctl_wdata  = req_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        hs         = ctl_valid & ctl_ready;
        req_ready  = hs ? (NUM_PORTS'(1) << grant_q) : '0;
        req_rvalid = ctl_write ? '0 : req_ready;
        req_rdata  = ctl_rdata;
    end

`ifdef DDR_ARB_PERF_CNT_EN
    logic [NUM_PORTS-1:0][PERF_W-1:0] perf_q, perf_d;
    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < NUM_PORTS; i++)
            perf_d[i] = perf_clr ? '0 : perf_q[i] + PERF_W'(req_ready[i]);
    end
    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) perf_q <= '0;
        else         perf_q <= perf_d;
    end
    assign perf_cnt = perf_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_cnt        = '0;
`endif
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed table-driven and sequence checks for ddr_port_arbiter.
module tb_ddr_port_arbiter;
    localparam int NP = 4, AW = 32, DW = 64, MH = 8;
    localparam logic [DW-1:0] RD = 64'h0123_4567_89AB_CDEF;
`ifdef DDR_ARB_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic              mem_clk = 1'b0, mem_rst = 1'b1;
    logic [NP-1:0]     req_valid = '0, req_write = '0, req_ready, req_rvalid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [DW-1:0]     req_rdata, ctl_wdata, ctl_rdata = RD;
    logic [AW-1:0]     ctl_addr;
    logic              ctl_valid, ctl_write, ctl_ready = 1'b0, perf_clr = 1'b0;
    logic [NP*32-1:0]  perf_cnt;
    int                checks = 0, errors = 0;

    ddr_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
        .mem_clk(mem_clk), .mem_rst(mem_rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .req_rvalid(req_rvalid),
        .req_rdata(req_rdata), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_valid(ctl_valid),
        .ctl_write(ctl_write), .ctl_ready(ctl_ready), .ctl_rdata(ctl_rdata),
        .perf_clr(perf_clr), .perf_cnt(perf_cnt)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic [3:0] rv, wr;
        logic       rdy, e_valid, e_write;
        logic [3:0] e_ready, e_rvalid;
        int         e_port;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic [3:0] rv, logic [3:0] wr, logic rdy, logic ev, logic ew,
                                logic [3:0] erdy, logic [3:0] erv, int ep);
        vec_t v;
        v.rv = rv; v.wr = wr; v.rdy = rdy; v.e_valid = ev; v.e_write = ew;
        v.e_ready = erdy; v.e_rvalid = erv; v.e_port = ep;
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_of(int p);
        return 32'h1000_0000 + AW'(p);
    endfunction

    function automatic logic [DW-1:0] wdata_of(int p);
        return 64'hD0D0_0000_0000_0000 + DW'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        mem_rst = 1'b1; req_valid = '0; req_write = '0; ctl_ready = 1'b0; perf_clr = 1'b0;
        repeat (2) @(posedge mem_clk);
        @(negedge mem_clk);
        mem_rst = 1'b0;
    endtask

    task automatic run_cont(input logic [3:0] rv, input int seq[4], input string name);
        do_reset();
        req_valid = rv; req_write = rv; ctl_ready = 1'b1;
        for (int c = 0; c < 4 * (MH + 1); c++) begin
            #1;
            check(name, req_ready, (c % (MH + 1) == 0) ? 4'b0 : 4'(1 << seq[c / (MH + 1)]));
            @(negedge mem_clk);
        end
        req_valid = '0;
    endtask

    task automatic txn(input int p);
        bit got = 0;
        req_valid = 4'(1 << p); req_write = '0; ctl_ready = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (req_ready[p]) got = 1;
            @(negedge mem_clk);
        end
        req_valid = '0;
        @(negedge mem_clk);
        check("txn_handshake", 64'(got), 64'd1);
    endtask

    initial begin
        int seq_a[4], seq_b[4];
        int exp_perf[4];
        for (int i = 0; i < NP; i++) begin
            req_addr[i*AW +: AW]  = addr_of(i);
            req_wdata[i*DW +: DW] = wdata_of(i);
        end
        vecs[0]  = mk(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b0100, 4'b0100, 2);
        vecs[2]  = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b0100, 4'b0100, 2);
        vecs[3]  = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b0100, 4'b0100, 2);
        vecs[4]  = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[5]  = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[6]  = mk(4'b1001, 4'b1000, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[7]  = mk(4'b1001, 4'b1000, 0, 1, 1, 4'b0000, 4'b0000, 3);
        vecs[8]  = mk(4'b1001, 4'b1000, 1, 1, 1, 4'b1000, 4'b0000, 3);
        vecs[9]  = mk(4'b0001, 4'b1000, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[10] = mk(4'b0001, 4'b1000, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[11] = mk(4'b0001, 4'b1000, 1, 1, 0, 4'b0001, 4'b0001, 0);
        vecs[12] = mk(4'b0000, 4'b1000, 1, 0, 0, 4'b0000, 4'b0000, 0);

        // Reset state
        do_reset();
        #1;
        check("rst_ctl_valid", ctl_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_rvalid", req_rvalid, 0);
        check("rst_perf_cnt", perf_cnt, 0);
        @(negedge mem_clk);

        // Table: port 2 reads, then round-robin from last_ptr=2, stall and owner release
        foreach (vecs[i]) begin
            req_valid = vecs[i].rv; req_write = vecs[i].wr; ctl_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_flags", i), {ctl_valid, req_ready, req_rvalid},
                  {vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_rvalid});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_write", i), ctl_write, vecs[i].e_write);
                check($sformatf("vec%0d_addr", i), ctl_addr, addr_of(vecs[i].e_port));
            end
            if (vecs[i].e_rvalid != 0) check($sformatf("vec%0d_rdata", i), req_rdata, RD);
            @(negedge mem_clk);
        end

        // Continuous requesters: MAX_HOLD groups with one bubble between them
        seq_a = '{0, 1, 0, 1};
        run_cont(4'b0011, seq_a, "rr_two_ports");
        seq_b = '{0, 1, 3, 0};
        run_cont(4'b1011, seq_b, "rr_three_ports");

        // Stall of a port 1 write, then the full hold must still be 8 handshakes
        do_reset();
        req_valid = 4'b0010; req_write = 4'b0010; ctl_ready = 1'b0;
        #1; check("stall_idle", ctl_valid, 0);
        @(negedge mem_clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_flags", {ctl_valid, ctl_write, req_ready}, {1'b1, 1'b1, 4'b0000});
            check("stall_addr", ctl_addr, addr_of(1));
            check("stall_wdata", ctl_wdata, wdata_of(1));
            @(negedge mem_clk);
        end
        ctl_ready = 1'b1;
        for (int c = 0; c < MH; c++) begin
            #1;
            check("stall_hs", {req_ready, req_rvalid}, {4'b0010, 4'b0000});
            @(negedge mem_clk);
        end
        #1; check("stall_release", {ctl_valid, req_ready}, 5'b0);
        @(negedge mem_clk);

        // Async reset mid-transaction with port 3 granted
        do_reset();
        req_valid = 4'b1000; ctl_ready = 1'b1;
        @(negedge mem_clk);
        #1; check("rst_mid_busy", ctl_valid, 1);
        mem_rst = 1'b1;
        #1; check("rst_mid_drop", {ctl_valid, req_ready}, 5'b0);
        req_valid = 4'b1001;
        @(negedge mem_clk);
        mem_rst = 1'b0;
        #1; check("rst_after_idle", ctl_valid, 0);
        @(negedge mem_clk);
        #1; check("rst_after_port0", req_ready, 4'b0001);
        @(negedge mem_clk);

        // Performance counters
        do_reset();
        for (int n = 0; n < 10; n++) txn(0);
        for (int n = 0; n < 4; n++) txn(2);
        exp_perf = '{10, 0, 4, 0};
        for (int p = 0; p < NP; p++)
            check($sformatf("perf_cnt%0d", p), perf_cnt[p*32 +: 32], PERF_EN ? 32'(exp_perf[p]) : 32'd0);
        perf_clr = 1'b1;
        @(negedge mem_clk);
        perf_clr = 1'b0;
        for (int p = 0; p < NP; p++)
            check($sformatf("perf_clr%0d", p), perf_cnt[p*32 +: 32], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single CPU-side transaction port of the DDR controller between NUM_PORTS requesters (CPU, DMA, display, ...).
- Round-robin grant; a granted requester keeps the port for up to MAX_HOLD back-to-back transactions.
- Sits directly in front of the controller. All logic is in the mem_clk domain.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 64, write/read data width.
- MAX_HOLD, 8, max consecutive accepted transactions per grant (matches burst length); must be >= 1.

Ports:
- mem_clk  in  1  clock.
- mem_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_write  in  NUM_PORTS  per-port 1=write, 0=read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- req_ready  out  NUM_PORTS  per-port accept.
- req_rvalid  out  NUM_PORTS  per-port read data valid.
- req_rdata  out  DATA_WIDTH  shared read data, qualified by req_rvalid.
- ctl_addr  out  ADDR_WIDTH  to controller address.
- ctl_wdata  out  DATA_WIDTH  to controller write data.
- ctl_valid  out  1  to controller valid.
- ctl_write  out  1  to controller write.
- ctl_ready  in  1  from controller ready.
- ctl_rdata  in  DATA_WIDTH  from controller read data, valid in the read handshake cycle.
- perf_clr  in  1  synchronous clear of performance counters.
- perf_cnt  out  NUM_PORTS*32  per-port accepted-transaction counts.

Behaviour:
- Handshake: a transaction completes in a cycle where valid&ready. Requesters hold valid, write, addr and wdata stable until ready. The controller returns ctl_rdata for reads in the handshake cycle.
- Reset (async, mem_rst=1):
  - state=IDLE, grant=0, last_ptr=NUM_PORTS-1 (port 0 wins first), hold_cnt=0.
  - ctl_valid=0, req_ready=0, req_rvalid=0, perf_cnt=0.
- IDLE:
  - ctl_valid=0, all req_ready=0.
  - If any req_valid: pick the first set bit searching last_ptr+1, last_ptr+2, ... (mod NUM_PORTS).
  - Register grant=pick, hold_cnt=0, go to BUSY next cycle.
  - Arbitration latency: request in IDLE -> ctl_valid the next cycle.
- BUSY:
  - ctl_valid = req_valid[grant]; ctl_addr, ctl_wdata and ctl_write are combinationally muxed from the granted port.
  - req_ready[i] = (i==grant) & req_valid[grant] & ctl_ready; 0 for all other ports.
  - req_rvalid[i] = req_ready[i] & ~req_write[grant]; req_rdata = ctl_rdata (passthrough).
  - On handshake with hold_cnt==MAX_HOLD-1: last_ptr=grant, go to IDLE.
  - On handshake otherwise: hold_cnt++, stay in BUSY.
  - With req_valid[grant]==0: last_ptr=grant, go to IDLE (releases an idle owner).
  - ctl_ready low: stall; grant and hold_cnt unchanged.
- Fairness: after a release, the releasing port has lowest priority. Every requester is served within (NUM_PORTS-1)*MAX_HOLD transactions of others.
- Released port still requesting: it re-arbitrates normally and may win again if it is alone (one-cycle bubble).
- Non-granted ports: ready stays 0; their requests wait.
- hold_cnt width: clog2(MAX_HOLD)+1; never wraps because it resets on each grant.
- Reset asserted mid-transaction: the transaction is dropped and ctl_valid falls immediately (async). The controller side is reset by the same signal.

Optional Feature:
- Macro: DDR_ARB_PERF_CNT_EN.
- Defined:
  - Per-port 32-bit counter increments on each req_ready[i] handshake and wraps at 2^32-1 -> 0.
  - perf_clr=1 zeroes all counters next cycle. If clear and increment coincide, clear wins.
- Undefined: perf_cnt tied to 0, perf_clr ignored, no counter flops. Ports remain present.

Decomposition:
- Package ddr_arb_pkg:
  - state enum {IDLE, BUSY}
  - PERF_W=32
  - function gnt_w(n) = clog2(n), minimum 1.
- Sub-module ddr_arb_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_ptr.
  - Outputs: pick index, any_req.

Test Plan:
- Only port 2 requests 3 reads -> ctl_valid one cycle after req_valid; 3 handshakes with req_rvalid[2]=1 and req_rdata=ctl_rdata; return to IDLE when valid drops.
- Ports 0 and 1 request continuously, MAX_HOLD=8, ctl_ready=1 -> grant sequence 0x8, 1x8, 0x8 ... with one bubble cycle between groups.
- Ports 0,1,3 request from reset -> first grant 0, then 1, then 3, then 0.
- ctl_ready held low 5 cycles during port 1 write -> req_ready[1]=0, ctl_* stable, hold_cnt unchanged; completes on the first ready cycle.
- mem_rst pulsed while BUSY with port 3 -> ctl_valid=0 immediately; after release port 0 wins if requesting.
- DDR_ARB_PERF_CNT_EN: 10 port-0 and 4 port-2 transactions -> perf_cnt = {0,4,0,10} by port; perf_clr -> all 0 next cycle. Without macro -> perf_cnt stays 0.
